// File: rtl/time_set_pkg.sv
// time_set_pkg
//   Shared definitions for the time/date entry controller:
//   - state_e       : edit-session state encoding
//   - FIELD_*       : field codes presented on the 'field' output
//   - BCD range limits for hour, minute, year, month and day
//   - DAYS_TBL      : days-per-month table indexed by binary month 1..12
//   - BCD helpers   : digit validity, increment, two-digit conversion, leap test
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOUR   = 3'd1,
    ST_MIN    = 3'd2,
    ST_YEAR   = 3'd3,
    ST_MONTH  = 3'd4,
    ST_DAY    = 3'd5,
    ST_COMMIT = 3'd6
  } state_e;

  localparam logic [2:0] FIELD_NONE  = 3'd0;
  localparam logic [2:0] FIELD_HOUR  = 3'd1;
  localparam logic [2:0] FIELD_MIN   = 3'd2;
  localparam logic [2:0] FIELD_YEAR  = 3'd3;
  localparam logic [2:0] FIELD_MONTH = 3'd4;
  localparam logic [2:0] FIELD_DAY   = 3'd5;

  localparam logic [7:0]  HOUR_MIN  = 8'h00;
  localparam logic [7:0]  HOUR_MAX  = 8'h23;
  localparam logic [7:0]  MIN_MIN   = 8'h00;
  localparam logic [7:0]  MIN_MAX   = 8'h59;
  localparam logic [15:0] YEAR_MIN  = 16'h2000;
  localparam logic [15:0] YEAR_MAX  = 16'h2199;
  localparam logic [7:0]  MONTH_MIN = 8'h01;
  localparam logic [7:0]  MONTH_MAX = 8'h12;
  localparam logic [7:0]  DAY_MIN   = 8'h01;

  // Entry 0 and 13..15 are unreachable for legal months; they hold 31 so
  // a corrupt month never produces a zero limit.
  localparam logic [7:0] DAYS_TBL [16] = '{
    8'h31, 8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31,
    8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h31, 8'h31, 8'h31
  };

  function automatic logic bcd_ok8(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic bcd_ok16(input logic [15:0] v);
    return bcd_ok8(v[15:8]) && bcd_ok8(v[7:0]);
  endfunction

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    if (v[7:0] == 8'h99) return {bcd_inc8(v[15:8]), 8'h00};
    return {v[15:8], bcd_inc8(v[7:0])};
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input logic [7:0] v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  // year = century*100 + yy; since 100 is a multiple of 4, year%4 == yy%4,
  // and year%400 == 0 reduces to yy == 0 with century%4 == 0.
  function automatic logic is_leap(input logic [15:0] year_bcd);
    logic [6:0] yy;
    logic [6:0] cc;
    yy = bcd2_to_bin(year_bcd[7:0]);
    cc = bcd2_to_bin(year_bcd[15:8]);
    if (yy != 7'd0) return (yy[1:0] == 2'b00);
    return (cc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/days_in_month.sv
// days_in_month
//   Combinational lookup of the last legal day of a month.
//   Ports:
//     month   in  8  month, BCD 01..12
//     leap    in  1  year is a leap year
//     max_day out 8  last day of that month, BCD (28/29/30/31)
module days_in_month
  import time_set_pkg::*;
(
  input  logic [7:0] month,
  input  logic       leap,
  output logic [7:0] max_day
);

  logic [3:0] month_idx;

  always_comb begin
    // BCD 10..12 folds to binary 10..12; 01..09 maps straight through.
    if (month[7:4] == 4'd1) month_idx = 4'd10 + month[3:0];
    else                    month_idx = month[3:0];

    max_day = DAYS_TBL[month_idx];
    if ((month_idx == 4'd2) && leap) max_day = 8'h29;
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   User time/date entry controller. SET enters an edit session, steps
//   hour -> min -> year -> month -> day and finally commits with a one-cycle
//   load strobe. INC increments the active field with BCD wrap and
//   leap-year-aware day limits.
//   Optional feature: define TIME_SET_TIMEOUT_EN to abort an idle session
//   after TIMEOUT_CYCLES cycles without a strobe.
//   Ports:
//     clk, rst                 clock (100 Hz tick), async active-high reset
//     set_pulse, inc_pulse     one-cycle button strobes
//     cur_hour/min/month/day   live counter values, BCD (8 bits)
//     cur_year                 live year, BCD (16 bits)
//     set_active               edit session in progress
//     field                    active field code (0 none, 1..5 hour..day)
//     blink_on                 blank phase for the active field
//     new_hour/min/month/day   shadow values, BCD (8 bits)
//     new_year                 shadow year, BCD (16 bits)
//     load                     one-cycle commit strobe
//   Strobe semantics: set_pulse and inc_pulse are sampled on every rising
//   edge with no backpressure; set_pulse has priority when both are high.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int BLINK_DIV      = 50,
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_pulse,
  input  logic        inc_pulse,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_min,
  input  logic [15:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  output logic        set_active,
  output logic [2:0]  field,
  output logic        blink_on,
  output logic [7:0]  new_hour,
  output logic [7:0]  new_min,
  output logic [15:0] new_year,
  output logic [7:0]  new_month,
  output logic [7:0]  new_day,
  output logic        load
);

  // One width serves both the blink and the timeout counter.
  localparam int CNT_MAX = (BLINK_DIV > TIMEOUT_CYCLES) ? BLINK_DIV : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [7:0]         hour_q, hour_d;
  logic [7:0]         min_q, min_d;
  logic [15:0]        year_q, year_d;
  logic [7:0]         month_q, month_d;
  logic [7:0]         day_q, day_d;
  logic               set_active_q, set_active_d;
  logic [2:0]         field_q, field_d;
  logic               load_q, load_d;
  logic               blink_q, blink_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;

  logic               capture;       // IDLE -> HOUR, shadows take cur_*
  logic               field_change;  // any accepted set_pulse
  logic               accept_inc;    // inc_pulse acted on in an edit state
  logic               date_inc;      // year or month was incremented
  logic               edit_q, edit_d;
  logic [7:0]         dim_max;

`ifdef TIME_SET_TIMEOUT_EN
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

  assign edit_q = (state_q inside {ST_HOUR, ST_MIN, ST_YEAR, ST_MONTH, ST_DAY});
  assign edit_d = (state_d inside {ST_HOUR, ST_MIN, ST_YEAR, ST_MONTH, ST_DAY});

  // Day limit follows the *next* month/year so increments and clamps see the
  // date that will exist after this edge.
  days_in_month u_dim (
    .month   (month_d),
    .leap    (is_leap(year_d)),
    .max_day (dim_max)
  );

  // Next state plus hour/minute/year/month shadows.
  always_comb begin
    state_d      = state_q;
    hour_d       = hour_q;
    min_d        = min_q;
    year_d       = year_q;
    month_d      = month_q;
    capture      = 1'b0;
    field_change = 1'b0;
    accept_inc   = 1'b0;
    date_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (set_pulse) begin
          state_d      = ST_HOUR;
          capture      = 1'b1;
          field_change = 1'b1;
          hour_d  = (bcd_ok8(cur_hour) && cur_hour <= HOUR_MAX) ? cur_hour : HOUR_MIN;
          min_d   = (bcd_ok8(cur_min) && cur_min <= MIN_MAX) ? cur_min : MIN_MIN;
          year_d  = (bcd_ok16(cur_year) && cur_year >= YEAR_MIN && cur_year <= YEAR_MAX)
                    ? cur_year : YEAR_MIN;
          month_d = (bcd_ok8(cur_month) && cur_month >= MONTH_MIN && cur_month <= MONTH_MAX)
                    ? cur_month : MONTH_MIN;
        end
      end

      ST_HOUR, ST_MIN, ST_YEAR, ST_MONTH, ST_DAY: begin
        if (set_pulse) begin
          field_change = 1'b1;
          case (state_q)
            ST_HOUR:  state_d = ST_MIN;
            ST_MIN:   state_d = ST_YEAR;
            ST_YEAR:  state_d = ST_MONTH;
            ST_MONTH: state_d = ST_DAY;
            default:  state_d = ST_COMMIT;
          endcase
        end else if (inc_pulse) begin
          accept_inc = 1'b1;
          case (state_q)
            ST_HOUR:  hour_d = (hour_q >= HOUR_MAX) ? HOUR_MIN : bcd_inc8(hour_q);
            ST_MIN:   min_d  = (min_q >= MIN_MAX) ? MIN_MIN : bcd_inc8(min_q);
            ST_YEAR: begin
              year_d   = (year_q >= YEAR_MAX) ? YEAR_MIN : bcd_inc16(year_q);
              date_inc = 1'b1;
            end
            ST_MONTH: begin
              month_d  = (month_q >= MONTH_MAX) ? MONTH_MIN : bcd_inc8(month_q);
              date_inc = 1'b1;
            end
            default: ;  // day handled with the day shadow below
          endcase
        end
`ifdef TIME_SET_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end
`endif
      end

      ST_COMMIT: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Day shadow: capture sanity check, increment wrap, and clamp after a
  // year/month change shrinks the month.
  always_comb begin
    day_d = day_q;
    if (capture) begin
      day_d = (bcd_ok8(cur_day) && cur_day >= DAY_MIN && cur_day <= dim_max)
              ? cur_day : DAY_MIN;
    end else if (accept_inc && state_q == ST_DAY) begin
      day_d = (day_q >= dim_max) ? DAY_MIN : bcd_inc8(day_q);
    end else if (date_inc && day_q > dim_max) begin
      day_d = dim_max;
    end
  end

  // Registered outputs and counters.
  always_comb begin
    set_active_d = (state_d != ST_IDLE);
    load_d       = (state_d == ST_COMMIT);
    case (state_d)
      ST_HOUR:  field_d = FIELD_HOUR;
      ST_MIN:   field_d = FIELD_MIN;
      ST_YEAR:  field_d = FIELD_YEAR;
      ST_MONTH: field_d = FIELD_MONTH;
      ST_DAY:   field_d = FIELD_DAY;
      default:  field_d = FIELD_NONE;
    endcase

    // Restarting the blink on every change keeps the edited digit visible.
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (!edit_d || field_change || accept_inc) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

`ifdef TIME_SET_TIMEOUT_EN
    if (set_pulse || inc_pulse || !edit_q) tmo_cnt_d = '0;
    else                                   tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hour_q       <= HOUR_MIN;
      min_q        <= MIN_MIN;
      year_q       <= YEAR_MIN;
      month_q      <= MONTH_MIN;
      day_q        <= DAY_MIN;
      set_active_q <= 1'b0;
      field_q      <= FIELD_NONE;
      load_q       <= 1'b0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      year_q       <= year_d;
      month_q      <= month_d;
      day_q        <= day_d;
      set_active_q <= set_active_d;
      field_q      <= field_d;
      load_q       <= load_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

`ifdef TIME_SET_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign set_active = set_active_q;
  assign field      = field_q;
  assign blink_on   = blink_q;
  assign load       = load_q;
  assign new_hour   = hour_q;
  assign new_min    = min_q;
  assign new_year   = year_q;
  assign new_month  = month_q;
  assign new_day    = day_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_pulse = 1'b0;
  logic        inc_pulse = 1'b0;
  logic [7:0]  cur_hour = 8'h00, cur_min = 8'h00, cur_month = 8'h01, cur_day = 8'h01;
  logic [15:0] cur_year = 16'h2000;
  logic        set_active, blink_on, load;
  logic [2:0]  field;
  logic [7:0]  new_hour, new_min, new_month, new_day;
  logic [15:0] new_year;

  int n_tests = 0;
  int n_fail  = 0;
  int load_cnt = 0;
  int load_mark;

  time_set_ctrl #(.BLINK_DIV(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .set_pulse(set_pulse), .inc_pulse(inc_pulse),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_year(cur_year),
    .cur_month(cur_month), .cur_day(cur_day),
    .set_active(set_active), .field(field), .blink_on(blink_on),
    .new_hour(new_hour), .new_min(new_min), .new_year(new_year),
    .new_month(new_month), .new_day(new_day), .load(load)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (load) load_cnt++;

  // ---------------- driver tasks ----------------
  task automatic apply(input logic s, input logic i);
    set_pulse = s;
    inc_pulse = i;
    @(posedge clk);
    #1;
    set_pulse = 1'b0;
    inc_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [15:0] y,
                         input logic [7:0] mo, input logic [7:0] d);
    cur_hour = h; cur_min = m; cur_year = y; cur_month = mo; cur_day = d;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        s;
    logic        i;
    logic        act;
    logic [2:0]  fld;
    logic        ld;
    logic [7:0]  h;
    logic [7:0]  m;
    logic [15:0] y;
    logic [7:0]  mo;
    logic [7:0]  d;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Session over cur 09:15 2019/04/13, one edit per field, then commit.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 8'h09, 8'h15, 16'h2019, 8'h04, 8'h13};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h10, 8'h15, 16'h2019, 8'h04, 8'h13};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 8'h10, 8'h15, 16'h2019, 8'h04, 8'h13};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h10, 8'h16, 16'h2019, 8'h04, 8'h13};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 8'h10, 8'h16, 16'h2019, 8'h04, 8'h13};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h04, 8'h13};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h04, 8'h13};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h05, 8'h13};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h06, 8'h13};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h06, 8'h13};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h06, 8'h14};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'h10, 8'h16, 16'h2020, 8'h06, 8'h14};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h06, 8'h14};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h10, 8'h16, 16'h2020, 8'h06, 8'h14};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_active", set_active, 0);
    check("rst_field",  field, 0);
    check("rst_blink",  blink_on, 0);
    check("rst_load",   load, 0);
    check("rst_hour",   new_hour, 16'h00);
    check("rst_min",    new_min, 16'h00);
    check("rst_year",   new_year, 16'h2000);
    check("rst_month",  new_month, 16'h01);
    check("rst_day",    new_day, 16'h01);

    // ---- table-driven session ----
    set_cur(8'h09, 8'h15, 16'h2019, 8'h04, 8'h13);
    for (int k = 0; k < 14; k++) begin
      apply(vecs[k].s, vecs[k].i);
      check($sformatf("v%0d_active", k), set_active, vecs[k].act);
      check($sformatf("v%0d_field", k),  field, vecs[k].fld);
      check($sformatf("v%0d_load", k),   load, vecs[k].ld);
      check($sformatf("v%0d_hour", k),   new_hour, vecs[k].h);
      check($sformatf("v%0d_min", k),    new_min, vecs[k].m);
      check($sformatf("v%0d_year", k),   new_year, vecs[k].y);
      check($sformatf("v%0d_month", k),  new_month, vecs[k].mo);
      check($sformatf("v%0d_day", k),    new_day, vecs[k].d);
    end
    check("load_once", load_cnt, 1);

    // ---- hour/min wrap, set+inc priority, reset mid-DAY ----
    set_cur(8'h23, 8'h59, 16'h2019, 8'h04, 8'h13);
    apply(1, 0);
    apply(0, 1);
    check("hour_wrap", new_hour, 16'h00);
    apply(1, 0);
    apply(0, 1);
    check("min_wrap", new_min, 16'h00);
    apply(1, 1);
    check("set_inc_field", field, 3);
    check("set_inc_min", new_min, 16'h00);
    check("set_inc_year", new_year, 16'h2019);
    apply(1, 0);
    apply(1, 0);
    check("in_day", field, 5);
    load_mark = load_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_active", set_active, 0);
    check("rst_mid_field", field, 0);
    check("rst_mid_year", new_year, 16'h2000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(0, 0);
    apply(0, 0);
    check("rst_mid_noload", load_cnt, load_mark);
    check("rst_mid_idle", set_active, 0);

    // ---- blink phase ----
    set_cur(8'h12, 8'h00, 16'h2019, 8'h04, 8'h13);
    apply(1, 0);
    check("blink_start", blink_on, 0);
    repeat (3) apply(0, 0);
    check("blink_before", blink_on, 0);
    apply(0, 0);
    check("blink_toggle", blink_on, 1);
    apply(0, 1);
    check("blink_inc_restart", blink_on, 0);
    check("blink_inc_hour", new_hour, 16'h13);
    do_reset();

    // ---- 2099 -> 2100 (not leap), Jan 29 -> Feb clamps to 28 ----
    set_cur(8'h00, 8'h00, 16'h2099, 8'h01, 8'h29);
    repeat (3) apply(1, 0);
    apply(0, 1);
    check("y2100_year", new_year, 16'h2100);
    check("y2100_day_kept", new_day, 16'h29);
    apply(1, 0);
    apply(0, 1);
    check("y2100_month", new_month, 16'h02);
    check("y2100_clamp", new_day, 16'h28);
    do_reset();

    // ---- 2199 wraps to 2000 (leap), Feb keeps 29, day 29 wraps to 01 ----
    set_cur(8'h00, 8'h00, 16'h2199, 8'h01, 8'h29);
    repeat (3) apply(1, 0);
    apply(0, 1);
    check("y2199_wrap", new_year, 16'h2000);
    apply(1, 0);
    apply(0, 1);
    check("y2000_feb", new_month, 16'h02);
    check("y2000_keep29", new_day, 16'h29);
    apply(1, 0);
    apply(0, 1);
    check("feb29_wrap", new_day, 16'h01);
    do_reset();

    // ---- 03/31 -> 04/30, and month 12 -> 01 ----
    set_cur(8'h00, 8'h00, 16'h2019, 8'h03, 8'h31);
    repeat (4) apply(1, 0);
    apply(0, 1);
    check("mar31_month", new_month, 16'h04);
    check("mar31_clamp", new_day, 16'h30);
    do_reset();
    set_cur(8'h00, 8'h00, 16'h2019, 8'h12, 8'h15);
    repeat (4) apply(1, 0);
    apply(0, 1);
    check("month_wrap", new_month, 16'h01);
    check("month_wrap_day", new_day, 16'h15);
    do_reset();

    // ---- out-of-range capture forced to minimums ----
    set_cur(8'h25, 8'h7A, 16'h1999, 8'h13, 8'h00);
    apply(1, 0);
    check("oor_hour", new_hour, 16'h00);
    check("oor_min", new_min, 16'h00);
    check("oor_year", new_year, 16'h2000);
    check("oor_month", new_month, 16'h01);
    check("oor_day", new_day, 16'h01);
    do_reset();

    // ---- idle in MONTH ----
    set_cur(8'h08, 8'h30, 16'h2019, 8'h04, 8'h13);
    repeat (4) apply(1, 0);
    check("tmo_in_month", field, 4);
    load_mark = load_cnt;
`ifdef TIME_SET_TIMEOUT_EN
    repeat (19) apply(0, 0);
    check("tmo_not_yet", field, 4);
    apply(0, 0);
    check("tmo_field", field, 0);
    check("tmo_active", set_active, 0);
    apply(0, 0);
    check("tmo_noload", load_cnt, load_mark);
`else
    repeat (25) apply(0, 0);
    check("no_tmo_field", field, 4);
    check("no_tmo_active", set_active, 1);
    check("no_tmo_noload", load_cnt, load_mark);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User time/date entry controller for the digital clock. It is the writing side of the clock counters: the display path reads hour/minute/date/year from the counter chain, and this block drives edited values back into that chain. It runs in the 100 Hz debounced-button domain, consumes one-pulse SET/INC strobes, and steps through hour, minute, year, month and day fields with per-field wrap and leap-year-aware day limits. On completion it issues a single-cycle load strobe with the full BCD time/date.

## Interface
Parameters:
- BLINK_DIV, 50 — clk cycles per blink half-period (0.5 s at 100 Hz).
- TIMEOUT_CYCLES, 3000 — idle cycles before an edit session aborts (30 s at 100 Hz).

Ports:
- clk  in  1  block clock (100 Hz tick domain).
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- set_pulse  in  1  one-cycle strobe: enter edit / advance field / commit.
- inc_pulse  in  1  one-cycle strobe: increment current field.
- cur_hour, cur_min  in  8 each  live counter values, BCD {tens, ones}.
- cur_year  in  16  live year, BCD 4 digits.
- cur_month, cur_day  in  8 each  live date, BCD.
- set_active  out  1  high while an edit session is in progress.
- field  out  3  current field code: 0 none, 1 hour, 2 min, 3 year, 4 month, 5 day.
- blink_on  out  1  display blank phase for the active field.
- new_hour, new_min, new_month, new_day  out  8 each  shadow values, BCD.
- new_year  out  16  shadow year, BCD.
- load  out  1  one-cycle strobe: counters take new_* and clear seconds to 00.

## Operation
- States: IDLE, HOUR, MIN, YEAR, MONTH, DAY, COMMIT.
- IDLE + set_pulse: capture all cur_* into shadows, go HOUR, set_active=1.
- set_pulse advances HOUR→MIN→YEAR→MONTH→DAY→COMMIT; COMMIT lasts one cycle (load=1), then IDLE.
- inc_pulse increments the active field in BCD:
  - hour 00..23 wraps to 00; min 00..59 wraps to 00;
  - year 2000..2199 wraps to 2000; month 01..12 wraps to 01;
  - day 01..max wraps to 01, where max = 31/30/28/29 per month and leap.
- Leap year: year%4==0 and (year%100!=0 or year%400==0), computed on the BCD shadow year.
- Day clamp: on any year or month increment, if shadow day > new max, day is set to max in the same cycle (e.g. 03/31 → inc month → 04/30).
- set_pulse and inc_pulse in the same cycle: set wins, inc is ignored.
- inc_pulse in IDLE or COMMIT: ignored.
- Captured cur_* values outside legal ranges are forced to the field minimum on capture.

## Timing
- Reset values: state IDLE, set_active 0, field 0, blink_on 0, load 0, new_hour 00, new_min 00, new_year 2000, new_month 01, new_day 01, blink and timeout counters 0.
- All outputs are registered. Field change and increment are visible the cycle after the strobe.
- load asserts exactly one cycle, the cycle after the final set_pulse. new_* are stable during load and hold afterwards.
- blink_on toggles every BLINK_DIV cycles while set_active is high. It restarts at 0 on each field change and each increment, so the edited field is visible immediately. It is forced to 0 in IDLE.
- Reset mid-session: immediate return to IDLE, no load.

## Configuration
- TIME_SET_TIMEOUT_EN defined: a counter clears on any strobe. Reaching TIMEOUT_CYCLES in HOUR..DAY returns the block to IDLE with no load and set_active=0.
- Not defined: no timeout counter. A session ends only through COMMIT or reset.

## Structure
- Package time_set_pkg: state enum, field codes, BCD range constants (hour/min/year/month limits), days-per-month table.
- Sub-module days_in_month: combinational, (month BCD, leap) → max day BCD. It is used by both increment and clamp logic.

## Test plan
- Reset, then set_pulse with cur 09:15 2019/04/13 → set_active=1, field=1, new_* equal captured values.
- In HOUR from 23, one inc_pulse → new_hour=00. In MIN from 59, one inc_pulse → new_min=00.
- Year 2100, month 02, day 29 → day clamps to 28. Year 2000 keeps 29. Year 2199 + inc → 2000.
- Full walk of five set_pulses → load high exactly one cycle with edited values, then IDLE and set_active=0.
- set_pulse and inc_pulse together in MIN → field advances to YEAR, new_min unchanged. rst asserted mid-DAY → IDLE, no load.
- With TIME_SET_TIMEOUT_EN and TIMEOUT_CYCLES=20: no strobes for 20 cycles in MONTH → IDLE, load never asserts.
